tcdm_bank_responder: RTL and testbench
======================================

TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

Interface
REQ-001 SHALL have parameter AddWidth, 10, word address width at the bank.
REQ-002 SHALL have parameter DataWidth, 32, data width; DataWidth multiple of 8.
REQ-003 SHALL have parameter BeWidth, DataWidth/8, byte-enable width (derived, not overridden).
REQ-004 SHALL have ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  network request.
- gnt_o  out  1  grant, combinational from req_i, state, mem_busy_i.
- add_i  in  AddWidth  word address.
- wen_i  in  1  1=write, 0=read.
- be_i  in  BeWidth  byte enables for writes.
- amo_i  in  2  00=none, 01=swap, 10=add, 11=or.
- wdata_i  in  DataWidth  write data / AMO operand.
- rdata_o  out  DataWidth  response data, valid cycle after grant.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write enable.
- mem_add_o  out  AddWidth  SRAM address.
- mem_be_o  out  BeWidth  SRAM byte enables.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_rdata_i  in  DataWidth  SRAM read data, valid 1 cycle after mem_req_o with mem_we_o=0.
- mem_busy_i  in  1  SRAM port taken by higher-priority agent this cycle.

Function
REQ-005 SHALL implement FSM states IDLE, AMO_WB, AMO_STALL.
REQ-006 IDLE: gnt_o = req_i & ~mem_busy_i; a granted request drives mem_req_o=1, mem_add_o=add_i same cycle.
REQ-007 IDLE plain access (amo_i=00): mem_we_o=wen_i, mem_be_o=be_i, mem_wdata_o=wdata_i; state stays IDLE.
REQ-008 IDLE AMO (amo_i!=00, wen_i ignored): SRAM read issued (mem_we_o=0); add_i, wdata_i, amo_i latched; next state AMO_WB.
REQ-009 Cycle after any granted read or AMO, rdata_o SHALL equal mem_rdata_i and be captured into hold register rdata_q.
REQ-010 All other cycles rdata_o SHALL equal rdata_q (held value, including after writes).
REQ-011 AMO_WB: gnt_o=0; result = swap: operand; add: old+operand modulo 2^DataWidth; or: old|operand; old = mem_rdata_i.
REQ-012 AMO_WB with mem_busy_i=0: mem_req_o=1, mem_we_o=1, mem_be_o all ones, latched address, result; next IDLE.
REQ-013 AMO_WB with mem_busy_i=1: mem_req_o=0; result captured in register; next AMO_STALL.
REQ-014 AMO_STALL: gnt_o=0; write of captured result issued first cycle mem_busy_i=0, then IDLE; rdata_o holds old value throughout.
REQ-015 mem_busy_i=1 in IDLE SHALL yield gnt_o=0, mem_req_o=0, no state change; requester retries.
REQ-016 mem_req_o SHALL never assert while mem_busy_i=1.
REQ-017 No request SHALL be granted in AMO_WB/AMO_STALL; AMO atomicity at bank guaranteed.
REQ-018 Ungranted req_i SHALL cause no SRAM access and no rdata_q update.

Reset
REQ-019 rst_ni low SHALL force state IDLE, rdata_q=0, latched address/operand/op/result=0, asynchronously.
REQ-020 During/after reset, before any request: gnt_o=0 (req_i=0), mem_req_o=0, rdata_o=0.
REQ-021 Reset mid-AMO SHALL abandon pending writeback (no SRAM write after release).

Verification
REQ-022 Write 0xDEADBEEF addr 5 be=1111, then read addr 5 -> gnt_o=1 both cycles, rdata_o=0xDEADBEEF cycle after read grant, held until next read.
REQ-023 Mem[3]=10, AMO add operand 7 addr 3 -> rdata_o=10 at T+1, gnt_o=0 at T+1 with req_i high, SRAM write 17 at T+1, subsequent read returns 17.
REQ-024 Mem[2]=0xF0, AMO or 0x0F, mem_busy_i=1 at T+1..T+3 -> state AMO_STALL, rdata_o=0xF0 held, write 0xFF at T+4, gnt_o=0 until T+5.
REQ-025 Add overflow: mem=0xFFFFFFFF, AMO add 2 -> write 0x00000001, rdata_o=0xFFFFFFFF.
REQ-026 mem_busy_i=1 with req_i=1 in IDLE -> gnt_o=0, mem_req_o=0, rdata_o unchanged; grant next cycle busy clears.
REQ-027 Assert rst_ni low during AMO_WB -> no SRAM write after release, rdata_o=0, state IDLE.

Source files
------------

// File: rtl/tcdm_bank_responder.sv
// TCDM bank-side responder: grants plain reads/writes in one cycle and performs
// swap/add/or atomics as an indivisible read-modify-write against a shared SRAM port.
module tcdm_bank_responder #(
  parameter int unsigned AddWidth  = 10,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned BeWidth  = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddWidth-1:0]  add_i,
  input  logic                 wen_i,
  input  logic [BeWidth-1:0]   be_i,
  input  logic [1:0]           amo_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddWidth-1:0]  mem_add_o,
  output logic [BeWidth-1:0]   mem_be_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic                 mem_busy_i
);

  typedef enum logic [1:0] {IDLE, AMO_WB, AMO_STALL} state_e;

  state_e               state_q, state_d;
  logic                 rvalid_q, rvalid_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic [AddWidth-1:0]  add_q, add_d;
  logic [DataWidth-1:0] operand_q, operand_d;
  logic [1:0]           amo_q, amo_d;
  logic [DataWidth-1:0] result_q, result_d;
  logic [DataWidth-1:0] amo_result;
  logic                 grant_idle;

  assign grant_idle = req_i & ~mem_busy_i;

  // Old value comes straight from the SRAM read issued in the grant cycle.
  always_comb begin
    unique case (amo_q)
      2'b10:   amo_result = mem_rdata_i + operand_q;
      2'b11:   amo_result = mem_rdata_i | operand_q;
      default: amo_result = operand_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      add_q     <= '0;
      operand_q <= '0;
      amo_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      add_q     <= add_d;
      operand_q <= operand_d;
      amo_q     <= amo_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rvalid_d  = 1'b0;
    rdata_d   = rvalid_q ? mem_rdata_i : rdata_q;
    add_d     = add_q;
    operand_d = operand_q;
    amo_d     = amo_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (grant_idle) begin
          if (amo_i != 2'b00) begin
            state_d   = AMO_WB;
            add_d     = add_i;
            operand_d = wdata_i;
            amo_d     = amo_i;
            rvalid_d  = 1'b1;
          end else begin
            rvalid_d  = ~wen_i;
          end
        end
      end
      AMO_WB: begin
        if (mem_busy_i) begin
          result_d = amo_result;
          state_d  = AMO_STALL;
        end else begin
          state_d  = IDLE;
        end
      end
      AMO_STALL: begin
        if (!mem_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_add_o   = add_i;
    mem_be_o    = be_i;
    mem_wdata_o = wdata_i;
    unique case (state_q)
      IDLE: begin
        gnt_o     = grant_idle;
        mem_req_o = grant_idle;
        mem_we_o  = (amo_i == 2'b00) & wen_i;
      end
      AMO_WB: begin
        mem_req_o   = ~mem_busy_i;
        mem_we_o    = 1'b1;
        mem_add_o   = add_q;
        mem_be_o    = '1;
        mem_wdata_o = amo_result;
      end
      AMO_STALL: begin
        mem_req_o   = ~mem_busy_i;
        mem_we_o    = 1'b1;
        mem_add_o   = add_q;
        mem_be_o    = '1;
        mem_wdata_o = result_q;
      end
      default: ;
    endcase
  end

  assign rdata_o = rvalid_q ? mem_rdata_i : rdata_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder with a behavioural SRAM and a read-response scoreboard.
module tb_tcdm_bank_responder;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i, wen_i, mem_busy_i;
  logic [9:0]  add_i;
  logic [3:0]  be_i;
  logic [1:0]  amo_i;
  logic [31:0] wdata_i, rdata_o;
  logic        gnt_o, mem_req_o, mem_we_o;
  logic [9:0]  mem_add_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned wr_count = 0;
  int unsigned busy_viol = 0;
  int unsigned wr_snap;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  tcdm_bank_responder #(.AddWidth(10), .DataWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i),
    .wen_i(wen_i), .be_i(be_i), .amo_i(amo_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_add_o(mem_add_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_busy_i(mem_busy_i)
  );

  // Single-port SRAM with one-cycle read latency and byte-enabled writes.
  always @(posedge clk) begin
    if (mem_req_o && mem_busy_i) busy_viol++;
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        wr_count++;
      end else begin
        mem_rdata_i <= mem[mem_add_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_rdata(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, rdata_o, e);
    end
  endtask

  // Inputs change on the falling edge; combinational outputs are sampled 1 ns later.
  task automatic step(input logic req, input logic wen, input logic [3:0] be, input logic [1:0] amo,
                      input logic [9:0] add, input logic [31:0] wd, input logic busy);
    @(negedge clk);
    req_i = req; wen_i = wen; be_i = be; amo_i = amo; add_i = add; wdata_i = wd; mem_busy_i = busy;
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 4'hF, 2'b00, a, d, 1'b0);
    chk("wr_gnt", {31'b0, gnt_o}, 32'd1);
    chk("wr_we", {31'b0, mem_we_o}, 32'd1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 2'b00, 10'd0, 32'd0, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i = 0; wen_i = 0; be_i = 0; amo_i = 0; add_i = 0; wdata_i = 0; mem_busy_i = 0;
    #1;
    chk("rst_gnt", {31'b0, gnt_o}, 32'd0);
    chk("rst_mreq", {31'b0, mem_req_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;
    idle();
    chk("post_rst_rdata", rdata_o, 32'd0);
    chk("post_rst_mreq", {31'b0, mem_req_o}, 32'd0);

    // Plain write then read back
    step(1'b1, 1'b1, 4'hF, 2'b00, 10'd5, 32'hDEADBEEF, 1'b0);
    chk("w5_gnt", {31'b0, gnt_o}, 32'd1);
    chk("w5_mreq", {31'b0, mem_req_o}, 32'd1);
    chk("w5_we", {31'b0, mem_we_o}, 32'd1);
    chk("w5_add", {22'b0, mem_add_o}, 32'd5);
    chk("w5_be", {28'b0, mem_be_o}, 32'hF);
    chk("w5_wdata", mem_wdata_o, 32'hDEADBEEF);
    step(1'b1, 1'b0, 4'h0, 2'b00, 10'd5, 32'd0, 1'b0);
    chk("r5_gnt", {31'b0, gnt_o}, 32'd1);
    chk("r5_we", {31'b0, mem_we_o}, 32'd0);
    chk("r5_rdata_held_pre", rdata_o, 32'd0);
    exp_q.push_back(32'hDEADBEEF);
    idle();
    pop_rdata("r5_rdata");
    idle();
    chk("r5_rdata_hold", rdata_o, 32'hDEADBEEF);

    // Single-byte write; response register keeps the old read value
    step(1'b1, 1'b1, 4'h1, 2'b00, 10'd5, 32'h00000011, 1'b0);
    chk("wb_be", {28'b0, mem_be_o}, 32'h1);
    idle();
    chk("wb_rdata_hold", rdata_o, 32'hDEADBEEF);
    step(1'b1, 1'b0, 4'h0, 2'b00, 10'd5, 32'd0, 1'b0);
    exp_q.push_back(32'hDEADBE11);
    idle();
    pop_rdata("rb_rdata");

    // AMO add, requester keeps req_i high during writeback
    wr(10'd3, 32'd10);
    step(1'b1, 1'b1, 4'hF, 2'b10, 10'd3, 32'd7, 1'b0);
    chk("add_gnt", {31'b0, gnt_o}, 32'd1);
    chk("add_rd_we", {31'b0, mem_we_o}, 32'd0);
    chk("add_rd_add", {22'b0, mem_add_o}, 32'd3);
    exp_q.push_back(32'd10);
    step(1'b1, 1'b0, 4'h0, 2'b00, 10'd3, 32'd0, 1'b0);
    pop_rdata("add_old");
    chk("add_wb_gnt", {31'b0, gnt_o}, 32'd0);
    chk("add_wb_mreq", {31'b0, mem_req_o}, 32'd1);
    chk("add_wb_we", {31'b0, mem_we_o}, 32'd1);
    chk("add_wb_add", {22'b0, mem_add_o}, 32'd3);
    chk("add_wb_be", {28'b0, mem_be_o}, 32'hF);
    chk("add_wb_data", mem_wdata_o, 32'd17);
    step(1'b1, 1'b0, 4'h0, 2'b00, 10'd3, 32'd0, 1'b0);
    chk("add_retry_gnt", {31'b0, gnt_o}, 32'd1);
    exp_q.push_back(32'd17);
    idle();
    pop_rdata("add_readback");

    // AMO or with the SRAM port taken for three cycles
    wr(10'd2, 32'h000000F0);
    step(1'b1, 1'b0, 4'hF, 2'b11, 10'd2, 32'h0000000F, 1'b0);
    chk("or_gnt", {31'b0, gnt_o}, 32'd1);
    exp_q.push_back(32'h000000F0);
    step(1'b1, 1'b0, 4'h0, 2'b00, 10'd2, 32'd0, 1'b1);
    pop_rdata("or_old");
    chk("or_t1_gnt", {31'b0, gnt_o}, 32'd0);
    chk("or_t1_mreq", {31'b0, mem_req_o}, 32'd0);
    for (int i = 2; i <= 3; i++) begin
      step(1'b1, 1'b0, 4'h0, 2'b00, 10'd2, 32'd0, 1'b1);
      chk("or_stall_gnt", {31'b0, gnt_o}, 32'd0);
      chk("or_stall_mreq", {31'b0, mem_req_o}, 32'd0);
      chk("or_stall_rdata", rdata_o, 32'h000000F0);
    end
    step(1'b1, 1'b0, 4'h0, 2'b00, 10'd2, 32'd0, 1'b0);
    chk("or_t4_gnt", {31'b0, gnt_o}, 32'd0);
    chk("or_t4_mreq", {31'b0, mem_req_o}, 32'd1);
    chk("or_t4_we", {31'b0, mem_we_o}, 32'd1);
    chk("or_t4_add", {22'b0, mem_add_o}, 32'd2);
    chk("or_t4_data", mem_wdata_o, 32'h000000FF);
    chk("or_t4_rdata", rdata_o, 32'h000000F0);
    step(1'b1, 1'b0, 4'h0, 2'b00, 10'd2, 32'd0, 1'b0);
    chk("or_t5_gnt", {31'b0, gnt_o}, 32'd1);
    exp_q.push_back(32'h000000FF);
    idle();
    pop_rdata("or_readback");

    // Add wraps modulo 2^32
    wr(10'd7, 32'hFFFFFFFF);
    step(1'b1, 1'b0, 4'hF, 2'b10, 10'd7, 32'd2, 1'b0);
    exp_q.push_back(32'hFFFFFFFF);
    idle();
    pop_rdata("ovf_old");
    chk("ovf_data", mem_wdata_o, 32'h00000001);

    // Swap
    wr(10'd8, 32'h12345678);
    step(1'b1, 1'b1, 4'h0, 2'b01, 10'd8, 32'hCAFEF00D, 1'b0);
    chk("swp_we", {31'b0, mem_we_o}, 32'd0);
    exp_q.push_back(32'h12345678);
    idle();
    pop_rdata("swp_old");
    chk("swp_data", mem_wdata_o, 32'hCAFEF00D);
    chk("swp_be", {28'b0, mem_be_o}, 32'hF);
    idle();
    chk("swp_mem", mem[8], 32'hCAFEF00D);

    // Busy in IDLE blocks the grant until it clears
    step(1'b1, 1'b0, 4'h0, 2'b00, 10'd5, 32'd0, 1'b1);
    chk("busy_gnt", {31'b0, gnt_o}, 32'd0);
    chk("busy_mreq", {31'b0, mem_req_o}, 32'd0);
    step(1'b1, 1'b0, 4'h0, 2'b00, 10'd5, 32'd0, 1'b0);
    chk("busy_rdata_hold", rdata_o, 32'h12345678);
    chk("busy_clear_gnt", {31'b0, gnt_o}, 32'd1);
    exp_q.push_back(32'hDEADBE11);
    idle();
    pop_rdata("busy_readback");

    // Reset during writeback abandons the write
    wr(10'd9, 32'd5);
    step(1'b1, 1'b0, 4'hF, 2'b10, 10'd9, 32'd1, 1'b0);
    exp_q.push_back(32'd5);
    step(1'b0, 1'b0, 4'h0, 2'b00, 10'd0, 32'd0, 1'b0);
    pop_rdata("rst_amo_old");
    wr_snap = wr_count;
    rst_ni = 1'b0;
    #1;
    chk("rst_amo_mreq", {31'b0, mem_req_o}, 32'd0);
    chk("rst_amo_rdata", rdata_o, 32'd0);
    idle();
    rst_ni = 1'b1;
    idle(); idle(); idle();
    chk("rst_amo_nowrite", wr_count, wr_snap);
    chk("rst_amo_mem", mem[9], 32'd5);
    chk("rst_amo_rdata_after", rdata_o, 32'd0);
    step(1'b1, 1'b0, 4'h0, 2'b00, 10'd9, 32'd0, 1'b0);
    chk("rst_amo_idle_gnt", {31'b0, gnt_o}, 32'd1);
    exp_q.push_back(32'd5);
    idle();
    pop_rdata("rst_amo_readback");

    chk("busy_violations", busy_viol, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
